// File: rtl/zbb_count_stage_if.sv
// Operand/result bus of the Zbb count stage, plus the side channel to the
// external single-cycle popcount unit.
//   slave  : view of the count stage (accepts ops, drives cpop_x and results)
//   master : view of the issuing/consuming logic and the popcount unit
interface zbb_count_stage_if #(
   parameter int unsigned TAG_W = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_op;
   logic [31:0]      in_rs1;
   logic [TAG_W-1:0] in_tag;
   logic [31:0]      cpop_x;
   logic [5:0]       cpop_res;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_result;
   logic [TAG_W-1:0] out_tag;

   modport slave (
      input  in_valid, in_op, in_rs1, in_tag, cpop_res, out_ready,
      output in_ready, cpop_x, out_valid, out_result, out_tag
   );

   modport master (
      output in_valid, in_op, in_rs1, in_tag, cpop_res, out_ready,
      input  in_ready, cpop_x, out_valid, out_result, out_tag
   );
endinterface

// File: rtl/zbb_count_stage.sv
// Two-stage elastic pipeline for the Zbb cpop / clz / ctz instructions.
// Stage 1 registers a mask whose popcount is the answer; stage 2 feeds that
// mask to the downstream popcount unit and registers the returned count.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : drop every in-flight operation at the next edge
//   bus        : slave side of zbb_count_stage_if (op in, mask out to the
//                popcount unit, count back, result out with tag)
module zbb_count_stage #(
   parameter int unsigned TAG_W = 5
) (
   input logic               clk,
   input logic               rst_n,
   input logic               flush,
   zbb_count_stage_if.slave  bus
);
   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 6;

   typedef enum logic [1:0] {
      OP_CPOP = 2'b00,
      OP_CLZ  = 2'b01,
      OP_CTZ  = 2'b10,
      OP_RSVD = 2'b11
   } op_e;

   logic              s1_valid;
   logic [XLEN-1:0]   s1_mask;
   logic [TAG_W-1:0]  s1_tag;
   logic              s2_valid;
   logic [CNT_W-1:0]  s2_cnt;
   logic [TAG_W-1:0]  s2_tag;

   logic [XLEN-1:0]   rs1_rev;
   logic [XLEN-1:0]   mask_c;
   logic              s2_free;
   logic              s1_adv;
   logic              in_ready_c;
   logic              in_fire;

   // Mask whose popcount is the result; ~v & (v-1) marks the trailing zeros.
   always_comb begin : mask_gen
      rs1_rev = '0;
      mask_c  = '0;
      for (int i = 0; i < XLEN; i++) begin
         rs1_rev[i] = bus.in_rs1[XLEN-1-i];
      end
      case (op_e'(bus.in_op))
         OP_CPOP: mask_c = bus.in_rs1;
         OP_CTZ:  mask_c = ~bus.in_rs1 & (bus.in_rs1 - XLEN'(1));
         OP_CLZ:  mask_c = ~rs1_rev & (rs1_rev - XLEN'(1));
         default: mask_c = '0;
      endcase
   end

   // Handshake / advance control; in_ready follows out_ready through one level.
   always_comb begin : adv_ctl
      s2_free    = !s2_valid || bus.out_ready;
      s1_adv     = s1_valid && s2_free;
      in_ready_c = !s1_valid || s1_adv;
      in_fire    = bus.in_valid && in_ready_c && !flush;
   end

   // Valid bits; flush wins over every advance.
   always_ff @(posedge clk or negedge rst_n) begin : valid_regs
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else if (flush) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         if (in_fire) begin
            s1_valid <= 1'b1;
         end else if (s1_adv) begin
            s1_valid <= 1'b0;
         end
         if (s1_adv) begin
            s2_valid <= 1'b1;
         end else if (s2_free) begin
            s2_valid <= 1'b0;
         end
      end
   end

   // Payload registers; they only move on a real transfer, so they hold under backpressure.
   always_ff @(posedge clk or negedge rst_n) begin : data_regs
      if (!rst_n) begin
         s1_mask <= '0;
         s1_tag  <= '0;
         s2_cnt  <= '0;
         s2_tag  <= '0;
      end else begin
         if (in_fire) begin
            s1_mask <= mask_c;
            s1_tag  <= bus.in_tag;
         end
         if (s1_adv && !flush) begin
            s2_cnt <= bus.cpop_res;
            s2_tag <= s1_tag;
         end
      end
   end

   assign bus.in_ready   = in_ready_c;
   assign bus.cpop_x     = s1_valid ? s1_mask : '0;
   assign bus.out_valid  = s2_valid;
   assign bus.out_result = {{(XLEN-CNT_W){1'b0}}, s2_cnt};
   assign bus.out_tag    = s2_tag;

endmodule
